// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor: the per-channel FSM state
// encoding and a constant-evaluable helper that sizes the shared cycle counter
// so it can hold the largest of the reset, stable and timeout periods.
// No ports (package).
// -----------------------------------------------------------------------------
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    // ceil(log2(v)), never less than 1 so a vector declared from it is legal.
    function automatic int clog2_min1(input longint v);
        int w;
        w = 0;
        for (int i = 0; i < 40; i++) begin
            if ((64'sd1 <<< i) < v) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Width of a counter that must reach (max(a, b, c) - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return clog2_min1(longint'(m));
    endfunction

endpackage

// File: rtl/pll_lock_channel.sv
// -----------------------------------------------------------------------------
// pll_lock_channel
// One supervised PLL: 2-flop synchroniser on the raw locked flag, a reset /
// wait / stabilise / run / fail FSM sharing a single cycle counter, retry
// tracking and a saturating lock-loss counter. All outputs are registered.
//
// Ports
//   refclk_i        reference clock, all logic in this domain
//   rst_n_i         synchronous active-low reset
//   pll_locked_i    raw (asynchronous) PLL locked flag
//   force_relock_i  single-cycle request to re-reset this PLL
//   pll_rst_o       active-high reset to the PLL
//   ready_o         PLL locked and stable
//   fail_o          retries exhausted, PLL held in reset
//   loss_cnt_o      saturating count of lock losses seen in RUN
// -----------------------------------------------------------------------------
module pll_lock_channel
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 8
) (
    input  logic             refclk_i,
    input  logic             rst_n_i,
    input  logic             pll_locked_i,
    input  logic             force_relock_i,
    output logic             pll_rst_o,
    output logic             ready_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] loss_cnt_o
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int RW = clog2_min1(longint'(MAX_RETRIES) + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    pll_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    retry_q;
    logic [RW-1:0]    retry_d;
    logic             sync1_q;
    logic             lk_q;
    logic             pll_rst_q;
    logic             ready_q;
    logic             fail_q;
    logic [CNT_W-1:0] loss_q;
    logic [CNT_W-1:0] loss_d;

    assign retry_d = retry_q + 1'b1;
    assign loss_d  = sat_inc(loss_q);

    always_ff @(posedge refclk_i) begin
        if (!rst_n_i) begin
            sync1_q   <= 1'b0;
            lk_q      <= 1'b0;
            state_q   <= RST_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
            loss_q    <= '0;
        end else begin
            sync1_q <= pll_locked_i;
            lk_q    <= sync1_q;

            // A relock request overrides everything, including a lock loss
            // seen in the same cycle, so it never bumps the loss counter.
            if (force_relock_i) begin
                state_q   <= RST_PLL;
                cnt_q     <= '0;
                retry_q   <= '0;
                pll_rst_q <= 1'b1;
                ready_q   <= 1'b0;
                fail_q    <= 1'b0;
            end else begin
                case (state_q)
                    RST_PLL: begin
                        if (cnt_q == RST_LAST) begin
                            state_q   <= WAIT_LOCK;
                            cnt_q     <= '0;
                            pll_rst_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        // Lock takes priority over a timeout on the same edge.
                        if (lk_q) begin
                            state_q <= STABLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == TMO_LAST) begin
                            retry_q   <= retry_d;
                            cnt_q     <= '0;
                            pll_rst_q <= 1'b1;
                            if (retry_d == RETRY_MAX) begin
                                state_q <= FAIL;
                                fail_q  <= 1'b1;
                            end else begin
                                state_q <= RST_PLL;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    STABLE: begin
                        // Any low restarts the wait with a fresh timeout window;
                        // the retry count is kept.
                        if (!lk_q) begin
                            state_q <= WAIT_LOCK;
                            cnt_q   <= '0;
                        end else if (cnt_q == STB_LAST) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                            retry_q <= '0;
                            ready_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RUN: begin
                        if (!lk_q) begin
                            state_q   <= RST_PLL;
                            cnt_q     <= '0;
                            pll_rst_q <= 1'b1;
                            ready_q   <= 1'b0;
                            loss_q    <= loss_d;
                        end
                    end
                    FAIL: begin
                        pll_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                        fail_q    <= 1'b1;
                    end
                    default: begin
                        state_q   <= RST_PLL;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pll_rst_o  = pll_rst_q;
    assign ready_o    = ready_q;
    assign fail_o     = fail_q;
    assign loss_cnt_o = loss_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Supervises NUM_PLLS independent PLL channels from the reference domain and
// publishes an all-channels-ready summary.
//
// Ports
//   refclk        50 MHz reference clock
//   rst_n         synchronous active-low reset
//   pll_locked    raw locked flags, one per PLL (asynchronous)
//   force_relock  per-channel single-cycle relock request
//   pll_rst       per-channel active-high PLL reset
//   ready         per-channel locked-and-stable flag
//   all_ready     AND of all ready bits (combinational from registered bits)
//   fail          per-channel retries-exhausted flag
//   loss_cnt      per-channel lock-loss counts, channel i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_PLLS            = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 8
) (
    input  logic                      refclk,
    input  logic                      rst_n,
    input  logic [NUM_PLLS-1:0]       pll_locked,
    input  logic [NUM_PLLS-1:0]       force_relock,
    output logic [NUM_PLLS-1:0]       pll_rst,
    output logic [NUM_PLLS-1:0]       ready,
    output logic                      all_ready,
    output logic [NUM_PLLS-1:0]       fail,
    output logic [NUM_PLLS*CNT_W-1:0] loss_cnt
);

    for (genvar i = 0; i < NUM_PLLS; i++) begin : g_ch
        pll_lock_channel #(
            .PLL_RST_CYCLES      (PLL_RST_CYCLES),
            .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
            .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
            .MAX_RETRIES         (MAX_RETRIES),
            .CNT_W               (CNT_W)
        ) u_ch (
            .refclk_i       (refclk),
            .rst_n_i        (rst_n),
            .pll_locked_i   (pll_locked[i]),
            .force_relock_i (force_relock[i]),
            .pll_rst_o      (pll_rst[i]),
            .ready_o        (ready[i]),
            .fail_o         (fail[i]),
            .loss_cnt_o     (loss_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign all_ready = &ready;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst_n;
    logic [1:0] pll_locked;
    logic [1:0] force_relock;
    logic [1:0] pll_rst;
    logic [1:0] ready;
    logic       all_ready;
    logic [1:0] fail;
    logic [7:0] loss_cnt;

    int tests_run;
    int tests_failed;

    pll_lock_supervisor #(
        .NUM_PLLS            (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2),
        .CNT_W               (4)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .ready        (ready),
        .all_ready    (all_ready),
        .fail         (fail),
        .loss_cnt     (loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Hold reset for a few edges, release it, and run the 4-edge PLL reset so
    // both channels sit in WAIT_LOCK with a fresh counter.
    task automatic start_channels();
        rst_n        = 1'b0;
        pll_locked   = 2'b00;
        force_relock = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        pll_locked   = 2'b00;
        force_relock = 2'b00;
        repeat (3) tick();
        tests_run++;
        if (pll_rst !== 2'b11) begin tests_failed++; $display("FAIL reset_pll_rst got %b want 11", pll_rst); end
        tests_run++;
        if (ready !== 2'b00 || all_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b/%b want 00/0", ready, all_ready); end
        tests_run++;
        if (fail !== 2'b00 || loss_cnt !== 8'h00) begin tests_failed++; $display("FAIL reset_fail_loss got %b/%h want 00/00", fail, loss_cnt); end
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests_run++;
            if (pll_rst !== ((k < 4) ? 2'b11 : 2'b00)) begin
                tests_failed++;
                $display("FAIL release_pll_rst edge %0d got %b want %b", k, pll_rst, (k < 4) ? 2'b11 : 2'b00);
            end
        end
        repeat (5) tick();
        tests_run++;
        if (ready !== 2'b00) begin tests_failed++; $display("FAIL unlocked_ready got %b want 00", ready); end
    endtask

    task automatic test_lock_latency();
        start_channels();
        pll_locked[0] = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (ready[0] !== 1'b0) begin tests_failed++; $display("FAIL lock_early got %b want 0", ready[0]); end
        tick();
        tests_run++;
        if (ready !== 2'b01 || all_ready !== 1'b0) begin tests_failed++; $display("FAIL lock_ch0 got %b/%b want 01/0", ready, all_ready); end
        pll_locked[1] = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (ready !== 2'b01 || all_ready !== 1'b0) begin tests_failed++; $display("FAIL lock_ch1_early got %b/%b want 01/0", ready, all_ready); end
        tick();
        tests_run++;
        if (ready !== 2'b11 || all_ready !== 1'b1) begin tests_failed++; $display("FAIL all_ready got %b/%b want 11/1", ready, all_ready); end
    endtask

    task automatic test_loss();
        start_channels();
        pll_locked[0] = 1'b1;
        repeat (11) tick();
        tests_run++;
        if (ready[0] !== 1'b1) begin tests_failed++; $display("FAIL loss_setup got %b want 1", ready[0]); end
        pll_locked[0] = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (ready[0] !== 1'b1 || pll_rst[0] !== 1'b0) begin tests_failed++; $display("FAIL loss_early got rdy %b rst %b want 1 0", ready[0], pll_rst[0]); end
        tick();
        tests_run++;
        if (ready[0] !== 1'b0 || pll_rst[0] !== 1'b1 || loss_cnt[3:0] !== 4'd1) begin
            tests_failed++;
            $display("FAIL loss_first got rdy %b rst %b cnt %0d want 0 1 1", ready[0], pll_rst[0], loss_cnt[3:0]);
        end
        // 4 reset edges + 1 to see lk + 8 stable edges = 13 edges back to RUN.
        for (int n = 2; n <= 16; n++) begin
            pll_locked[0] = 1'b1;
            repeat (13) tick();
            tests_run++;
            if (ready[0] !== 1'b1) begin tests_failed++; $display("FAIL relock_%0d got %b want 1", n, ready[0]); end
            pll_locked[0] = 1'b0;
            repeat (3) tick();
            tests_run++;
            if (loss_cnt[3:0] !== ((n > 15) ? 4'd15 : 4'(n))) begin
                tests_failed++;
                $display("FAIL loss_count_%0d got %0d want %0d", n, loss_cnt[3:0], (n > 15) ? 15 : n);
            end
        end
    endtask

    task automatic test_fail();
        start_channels();
        repeat (31) tick();
        tests_run++;
        if (pll_rst[1] !== 1'b0) begin tests_failed++; $display("FAIL timeout_early got %b want 0", pll_rst[1]); end
        tick();
        tests_run++;
        if (pll_rst[1] !== 1'b1 || fail[1] !== 1'b0) begin tests_failed++; $display("FAIL retry1 got rst %b fail %b want 1 0", pll_rst[1], fail[1]); end
        repeat (3) tick();
        tests_run++;
        if (pll_rst[1] !== 1'b1) begin tests_failed++; $display("FAIL retry1_hold got %b want 1", pll_rst[1]); end
        tick();
        tests_run++;
        if (pll_rst[1] !== 1'b0) begin tests_failed++; $display("FAIL retry1_end got %b want 0", pll_rst[1]); end
        repeat (31) tick();
        tests_run++;
        if (fail[1] !== 1'b0 || pll_rst[1] !== 1'b0) begin tests_failed++; $display("FAIL fail_early got fail %b rst %b want 0 0", fail[1], pll_rst[1]); end
        tick();
        tests_run++;
        if (fail[1] !== 1'b1 || pll_rst[1] !== 1'b1) begin tests_failed++; $display("FAIL fail_enter got fail %b rst %b want 1 1", fail[1], pll_rst[1]); end
        repeat (20) tick();
        tests_run++;
        if (fail !== 2'b11 || pll_rst !== 2'b11) begin tests_failed++; $display("FAIL fail_hold got fail %b rst %b want 11 11", fail, pll_rst); end
        force_relock = 2'b10;
        tick();
        force_relock = 2'b00;
        tests_run++;
        if (fail !== 2'b01 || pll_rst[1] !== 1'b1) begin tests_failed++; $display("FAIL force_clear got fail %b rst %b want 01 1", fail, pll_rst[1]); end
        repeat (3) tick();
        tests_run++;
        if (pll_rst[1] !== 1'b1) begin tests_failed++; $display("FAIL force_rst_hold got %b want 1", pll_rst[1]); end
        tick();
        tests_run++;
        if (pll_rst !== 2'b01) begin tests_failed++; $display("FAIL force_rst_end got %b want 01", pll_rst); end
    endtask

    task automatic test_stable_glitch();
        start_channels();
        pll_locked[0] = 1'b1;
        // STABLE entered 3 edges after the rise; lk is seen low with count 5.
        repeat (6) tick();
        pll_locked[0] = 1'b0;
        repeat (3) tick();
        pll_locked[0] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            tests_run++;
            if (ready[0] !== ((k == 11) ? 1'b1 : 1'b0)) begin
                tests_failed++;
                $display("FAIL glitch_relatch edge %0d got %b want %b", k, ready[0], (k == 11) ? 1'b1 : 1'b0);
            end
        end
    endtask

    task automatic test_force_loss_and_reset();
        start_channels();
        pll_locked[0] = 1'b1;
        repeat (11) tick();
        tests_run++;
        if (ready[0] !== 1'b1) begin tests_failed++; $display("FAIL force_setup got %b want 1", ready[0]); end
        pll_locked[0] = 1'b0;
        repeat (2) tick();
        force_relock = 2'b01;
        tick();
        force_relock = 2'b00;
        tests_run++;
        if (ready[0] !== 1'b0 || pll_rst[0] !== 1'b1 || loss_cnt[3:0] !== 4'd0) begin
            tests_failed++;
            $display("FAIL force_vs_loss got rdy %b rst %b cnt %0d want 0 1 0", ready[0], pll_rst[0], loss_cnt[3:0]);
        end
        repeat (6) tick();
        tests_run++;
        if (pll_rst !== 2'b00) begin tests_failed++; $display("FAIL wait_lock_state got %b want 00", pll_rst); end
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (pll_rst !== 2'b11 || ready !== 2'b00 || all_ready !== 1'b0 || fail !== 2'b00 || loss_cnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrun_reset got rst %b rdy %b all %b fail %b loss %h want 11 00 0 00 00",
                     pll_rst, ready, all_ready, fail, loss_cnt);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        pll_locked   = 2'b00;
        force_relock = 2'b00;
        test_reset();
        test_lock_latency();
        test_loss();
        test_fail();
        test_stable_glitch();
        test_force_loss_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
